fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Circular instruction queue between fetch_stage and the decode pipeline register.
- Decouples fetch from decode stalls: fetch keeps issuing while decode is held, until the queue is full.
- Backpressure goes to fetch as a stall signal; a taken branch (br_tk) flushes every queued entry.
- Entries carry PC and instruction word, delivered to decode in program order.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- ARCH_LEN, ARCH_LEN from constants_pkg (32), PC width.
- INST_LEN, 32, instruction word width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- push_valid_in  in  1  fetch presents a valid instruction this cycle
- push_pc_in  in  ARCH_LEN  PC of pushed instruction
- push_inst_in  in  INST_LEN  pushed instruction word
- stall_fet_out  out  1  queue full; fetch must hold its PC and not advance
- pop_valid_out  out  1  head entry valid for decode
- pop_pc_out  out  ARCH_LEN  head entry PC
- pop_inst_out  out  INST_LEN  head entry instruction
- stall_dec_in  in  1  decode stalled; head is not consumed
- flush_in  in  1  branch taken (br_tk); discard all entries
- count_out  out  $clog2(DEPTH+1)  current occupancy (debug/verification)

Behaviour:
- Storage: DEPTH-entry array of {pc, inst}.
- Pointers: rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH with natural overflow. Separate count register, 0..DEPTH.
- Outputs are combinational from registered state:
  - stall_fet_out = (count == DEPTH).
  - pop_valid_out = (count != 0) & ~flush_in.
  - pop_pc_out / pop_inst_out = array[rd_ptr]. Data is don't-care when pop_valid_out = 0 and must not be consumed.
- Push accepted on a rising edge when push_valid_in & ~stall_fet_out & ~flush_in. It writes array[wr_ptr] and increments wr_ptr.
- Pop accepted on a rising edge when pop_valid_out & ~stall_dec_in. It increments rd_ptr.
- count_next = count + push_acc - pop_acc.
- Latency: a pushed instruction is visible at the pop side the cycle after acceptance. There is no same-cycle bypass, even when empty.
- Full: stall_fet_out = 1 and pushes are ignored, even if a pop happens in the same cycle. The free slot becomes usable the next cycle. Fetch must re-present the same instruction.
- Empty: pop_valid_out = 0 and stall_dec_in has no effect.
- Simultaneous push and pop when neither full nor empty: both take effect and count is unchanged.
- Flush (flush_in = 1):
  - Next cycle, rd_ptr = wr_ptr = 0 and count = 0.
  - Any push in the flush cycle is discarded.
  - pop_valid_out is forced to 0 in the flush cycle.
  - Array contents are not cleared.
- Reset (rst = 1): identical effect to flush and has priority over it. Reset values: count = 0, pointers = 0. Outputs after reset: stall_fet_out = 0, pop_valid_out = 0, count_out = 0.
- Reset mid-operation discards all entries with no partial pop.
- No X propagation on control outputs from uninitialised array data: pop_valid_out depends only on count and flush_in.

Test Plan:
- Reset, then push PCs 0x00, 0x04, 0x08 on consecutive cycles with stall_dec_in = 0 -> pop_valid_out rises one cycle after the first push; PCs pop in order 0x00, 0x04, 0x08; count_out peaks at 1.
- stall_dec_in = 1, push 5 instructions (DEPTH = 4) -> stall_fet_out = 1 after the 4th accept; 5th not accepted; count_out = 4. Release stall_dec_in and hold push of the 5th -> it is accepted the cycle after the first pop; order preserved.
- Full queue, push_valid_in = 1, pop in the same cycle -> push rejected that cycle, count_out = 3 next cycle, push accepted the following cycle, count_out = 4.
- Wrap-around: 10 pushes interleaved with pops keeping count at 2 -> all 10 PCs delivered in order; pointers wrap without loss.
- 3 entries queued; flush_in = 1 with push_valid_in = 1 (PC 0x40) -> pop_valid_out = 0 that cycle; next cycle count_out = 0; 0x40 never appears. Push 0x80 -> it is the next popped PC.
- rst asserted with 2 entries queued and stall_dec_in = 0 -> no pop of the head occurs; next cycle count_out = 0, stall_fet_out = 0, pop_valid_out = 0.

Source files
------------

// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode.
// Holds {pc, inst} in program order; branch flush empties it.
module fetch_buffer #(
    parameter int DEPTH    = 4,
    parameter int ARCH_LEN = 32,
    parameter int INST_LEN = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid_in,
    input  logic [ARCH_LEN-1:0]        push_pc_in,
    input  logic [INST_LEN-1:0]        push_inst_in,
    output logic                       stall_fet_out,
    output logic                       pop_valid_out,
    output logic [ARCH_LEN-1:0]        pop_pc_out,
    output logic [INST_LEN-1:0]        pop_inst_out,
    input  logic                       stall_dec_in,
    input  logic                       flush_in,
    output logic [$clog2(DEPTH+1)-1:0] count_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ARCH_LEN-1:0] pc_q   [DEPTH];
    logic [INST_LEN-1:0] inst_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic push_acc;
    logic pop_acc;

    assign stall_fet_out = (count_q == CW'(DEPTH));
    assign pop_valid_out = (count_q != '0) & ~flush_in;
    assign pop_pc_out    = pc_q[rd_ptr_q];
    assign pop_inst_out  = inst_q[rd_ptr_q];
    assign count_out     = count_q;

    // Full blocks push even if a pop frees a slot this cycle.
    assign push_acc = push_valid_in & ~stall_fet_out & ~flush_in;
    assign pop_acc  = pop_valid_out & ~stall_dec_in;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_in) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_acc)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_acc) - CW'(pop_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_acc && !rst) begin
            pc_q[wr_ptr_q]   <= push_pc_in;
            inst_q[wr_ptr_q] <= push_inst_in;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer.
// Each scenario task drives inputs and checks outputs inline.
module tb_fetch_buffer;

    logic        clk;
    logic        rst;
    logic        push_valid_in;
    logic [31:0] push_pc_in;
    logic [31:0] push_inst_in;
    logic        stall_fet_out;
    logic        pop_valid_out;
    logic [31:0] pop_pc_out;
    logic [31:0] pop_inst_out;
    logic        stall_dec_in;
    logic        flush_in;
    logic [2:0]  count_out;

    int errors = 0;
    int checks = 0;

    fetch_buffer #(.DEPTH(4), .ARCH_LEN(32), .INST_LEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .push_valid_in (push_valid_in),
        .push_pc_in    (push_pc_in),
        .push_inst_in  (push_inst_in),
        .stall_fet_out (stall_fet_out),
        .pop_valid_out (pop_valid_out),
        .pop_pc_out    (pop_pc_out),
        .pop_inst_out  (pop_inst_out),
        .stall_dec_in  (stall_dec_in),
        .flush_in      (flush_in),
        .count_out     (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        push_valid_in = v;
        push_pc_in    = pc;
        push_inst_in  = inst_of(pc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0);
        stall_dec_in = 1'b0;
        flush_in = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (count_out !== 3'd0) begin
            errors++;
            $display("FAIL reset_count got=%0d exp=0", count_out);
        end
        checks++;
        if (stall_fet_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall got=%b exp=0", stall_fet_out);
        end
        checks++;
        if (pop_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b exp=0", pop_valid_out);
        end
    endtask

    task automatic test_in_order();
        stall_dec_in = 1'b0;
        drive(1'b1, 32'h00);
        #1;
        checks++;
        if (pop_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL no_bypass got=%b exp=0", pop_valid_out);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive(1'b1, 32'(4 * (i + 1)));
            else drive(1'b0, 32'h0);
            #1;
            checks++;
            if (pop_valid_out !== 1'b1 || pop_pc_out !== 32'(4 * i)) begin
                errors++;
                $display("FAIL inorder_pop%0d got v=%b pc=%h exp v=1 pc=%h",
                         i, pop_valid_out, pop_pc_out, 32'(4 * i));
            end
            checks++;
            if (count_out !== 3'd1) begin
                errors++;
                $display("FAIL inorder_cnt%0d got=%0d exp=1", i, count_out);
            end
            step();
        end
        checks++;
        if (pop_valid_out !== 1'b0 || count_out !== 3'd0) begin
            errors++;
            $display("FAIL inorder_empty got v=%b cnt=%0d exp v=0 cnt=0",
                     pop_valid_out, count_out);
        end
    endtask

    task automatic test_full();
        stall_dec_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i));
            step();
        end
        drive(1'b1, 32'h110);
        #1;
        checks++;
        if (stall_fet_out !== 1'b1 || count_out !== 3'd4) begin
            errors++;
            $display("FAIL full_state got st=%b cnt=%0d exp st=1 cnt=4",
                     stall_fet_out, count_out);
        end
        step();
        checks++;
        if (count_out !== 3'd4 || pop_pc_out !== 32'h100) begin
            errors++;
            $display("FAIL full_hold got cnt=%0d pc=%h exp cnt=4 pc=100",
                     count_out, pop_pc_out);
        end
        stall_dec_in = 1'b0;
        step();
        checks++;
        if (count_out !== 3'd3 || stall_fet_out !== 1'b0 ||
            pop_pc_out !== 32'h104) begin
            errors++;
            $display("FAIL full_poprej got cnt=%0d st=%b pc=%h exp 3 0 104",
                     count_out, stall_fet_out, pop_pc_out);
        end
        stall_dec_in = 1'b1;
        step();
        checks++;
        if (count_out !== 3'd4 || stall_fet_out !== 1'b1) begin
            errors++;
            $display("FAIL full_reacc got cnt=%0d st=%b exp cnt=4 st=1",
                     count_out, stall_fet_out);
        end
        drive(1'b0, 32'h0);
        stall_dec_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (pop_valid_out !== 1'b1 ||
                pop_pc_out !== 32'h104 + 32'(4 * i) ||
                pop_inst_out !== inst_of(32'h104 + 32'(4 * i))) begin
                errors++;
                $display("FAIL full_drain%0d got v=%b pc=%h exp pc=%h", i,
                         pop_valid_out, pop_pc_out, 32'h104 + 32'(4 * i));
            end
            step();
        end
        checks++;
        if (count_out !== 3'd0) begin
            errors++;
            $display("FAIL full_end got=%0d exp=0", count_out);
        end
    endtask

    task automatic test_wrap();
        int exp_i = 0;
        int pushed = 0;
        for (int c = 0; c < 12; c++) begin
            stall_dec_in = (c < 2) ? 1'b1 : 1'b0;
            if (pushed < 10) drive(1'b1, 32'h200 + 32'(4 * pushed));
            else drive(1'b0, 32'h0);
            #1;
            if (c >= 2 && c < 10) begin
                checks++;
                if (count_out !== 3'd2) begin
                    errors++;
                    $display("FAIL wrap_cnt%0d got=%0d exp=2", c, count_out);
                end
            end
            if (pop_valid_out && !stall_dec_in) begin
                checks++;
                if (pop_pc_out !== 32'h200 + 32'(4 * exp_i)) begin
                    errors++;
                    $display("FAIL wrap_pop%0d got=%h exp=%h", exp_i,
                             pop_pc_out, 32'h200 + 32'(4 * exp_i));
                end
                exp_i++;
            end
            if (push_valid_in && !stall_fet_out) pushed++;
            step();
        end
        checks++;
        if (exp_i != 10 || count_out !== 3'd0) begin
            errors++;
            $display("FAIL wrap_total got pops=%0d cnt=%0d exp pops=10 cnt=0",
                     exp_i, count_out);
        end
    endtask

    task automatic test_flush();
        stall_dec_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i));
            step();
        end
        flush_in = 1'b1;
        stall_dec_in = 1'b0;
        drive(1'b1, 32'h40);
        #1;
        checks++;
        if (pop_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid got=%b exp=0", pop_valid_out);
        end
        step();
        flush_in = 1'b0;
        drive(1'b1, 32'h80);
        #1;
        checks++;
        if (count_out !== 3'd0 || pop_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty got cnt=%0d v=%b exp cnt=0 v=0",
                     count_out, pop_valid_out);
        end
        step();
        drive(1'b0, 32'h0);
        #1;
        checks++;
        if (pop_valid_out !== 1'b1 || pop_pc_out !== 32'h80) begin
            errors++;
            $display("FAIL flush_next got v=%b pc=%h exp v=1 pc=80",
                     pop_valid_out, pop_pc_out);
        end
        step();
        checks++;
        if (count_out !== 3'd0) begin
            errors++;
            $display("FAIL flush_end got=%0d exp=0", count_out);
        end
    endtask

    task automatic test_reset_mid();
        stall_dec_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i));
            step();
        end
        drive(1'b0, 32'h0);
        stall_dec_in = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (count_out !== 3'd0 || stall_fet_out !== 1'b0 ||
            pop_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL rstmid got cnt=%0d st=%b v=%b exp 0 0 0",
                     count_out, stall_fet_out, pop_valid_out);
        end
        drive(1'b1, 32'h600);
        step();
        drive(1'b0, 32'h0);
        #1;
        checks++;
        if (pop_valid_out !== 1'b1 || pop_pc_out !== 32'h600 ||
            count_out !== 3'd1) begin
            errors++;
            $display("FAIL rstmid_next got v=%b pc=%h cnt=%0d exp 1 600 1",
                     pop_valid_out, pop_pc_out, count_out);
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        flush_in = 1'b0;
        stall_dec_in = 1'b0;
        push_valid_in = 1'b0;
        push_pc_in = '0;
        push_inst_in = '0;
        test_reset();
        test_in_order();
        test_full();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
